stream_unpacker: RTL

// - Read-side consumer of the 72-bit BRAM FIFO output stream (ms_* of the FIFO).
// - Accepts one wide word and emits it as IN_W/OUT_W narrow lanes, LSB lane first.
// - Gives full throughput: the next wide word is accepted on the last-lane cycle.
// - Sits between the FIFO master port and the narrow accelerator input.
//

---
 rtl/stream_unpacker.sv | 104 ++++++++++
 1 files changed

// File: rtl/stream_unpacker.sv
// stream_unpacker: splits each IN_W-bit input word into IN_W/OUT_W lanes of
// OUT_W bits and emits them one per cycle, LSB lane first. The next word is
// accepted on the cycle its predecessor's last lane leaves, so back-to-back
// words stream with no bubble.
//
// Handshake (both sides): a beat transfers on a posedge where valid && ready.
// A producer holds valid/data stable until the beat is taken. ms_valid is
// purely registered and never looks at ms_ready. ss_ready is combinational.
//
// Optional feature: define UNPACK_LAST_EN to add the ms_last output, which
// marks the final lane of each word.
module stream_unpacker #(
    parameter int IN_W  = 72,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  ss_data,
    input  logic             ss_valid,
    output logic             ss_ready,
    output logic [OUT_W-1:0] ms_data,
    output logic             ms_valid,
    input  logic             ms_ready
`ifdef UNPACK_LAST_EN
    ,
    output logic             ms_last
`endif
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if ((IN_W % OUT_W) != 0) begin : g_bad_ratio
        $error("stream_unpacker: IN_W must be a multiple of OUT_W");
    end

    // EMPTY: no word held. HOLD: sreg holds a word, lane cnt is on ms_data.
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_lane;
    logic              accept;

    assign last_lane = (state_q == HOLD) && (cnt_q == LAST);
    assign ss_ready  = !reset && ((state_q == EMPTY) || (ms_ready && last_lane));
    assign accept    = ss_valid && ss_ready;
    assign ms_valid  = (state_q == HOLD);
    assign ms_data   = sreg_q[OUT_W-1:0];
`ifdef UNPACK_LAST_EN
    assign ms_last   = last_lane;
`endif

    // Next-state logic: load a new word, shift to the next lane, or freeze.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    sreg_d  = ss_data;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ms_ready) begin
                    if (cnt_q != LAST) begin
                        sreg_d = sreg_q >> OUT_W;
                        cnt_d  = cnt_q + CW'(1);
                    end else if (accept) begin
                        // Zero-bubble handover: the new word replaces the
                        // one whose last lane is leaving this cycle.
                        sreg_d = ss_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; reset discards any partially emitted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
